// File: rtl/tinyml_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : tinyml_pkg
//  Purpose   : Widths and state encoding shared by the dot-product sequencer
//              and the 8x8+16 multiply-accumulate datapath.
//  Revision  : 1.0 - initial release
// ============================================================================
package tinyml_pkg;

   localparam int DATA_W = 8;
   localparam int ACC_W  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FEED = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } dot_state_t;

endpackage : tinyml_pkg
`default_nettype wire

// File: rtl/tinyml_dot_seq.sv
`default_nettype none
// ============================================================================
//  Module    : tinyml_dot_seq
//  Purpose   : Dot-product sequencer. Streams operand pairs into an external
//              MAC (y = a*b + c), feeds each result back as the next addend
//              and presents the final accumulation on a valid/ready port.
//  Revision  : 1.0 - initial release
// ============================================================================
module tinyml_dot_seq
   import tinyml_pkg::*;
#(
   parameter int LEN_W   = 8,
   parameter int MAC_LAT = 1
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic [LEN_W-1:0]  len_i,
   input  logic [ACC_W-1:0]  bias_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_a_i,
   input  logic [DATA_W-1:0] in_b_i,
   output logic [DATA_W-1:0] mac_a_o,
   output logic [DATA_W-1:0] mac_b_o,
   output logic [ACC_W-1:0]  mac_c_o,
   input  logic [ACC_W-1:0]  mac_y_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [ACC_W-1:0]  out_data_o,
   output logic              busy_o
);

   // Counter must be able to hold MAC_LAT; a zero-latency MAC still needs 1 bit.
   localparam int CNT_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

   dot_state_t        state_q;
   logic [ACC_W-1:0]  acc_q;
   logic [LEN_W-1:0]  rem_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] mac_a_q;
   logic [DATA_W-1:0] mac_b_q;
   logic [ACC_W-1:0]  mac_c_q;
   logic [ACC_W-1:0]  out_data_q;
   logic              in_ready_q;
   logic              out_valid_q;
   logic              busy_q;

   // Remaining count after the element currently in the MAC retires.
   logic [LEN_W-1:0]  rem_d;

   // Decrement of the remaining-element count.
   always_comb begin
      rem_d = rem_q - LEN_W'(1);
   end

   // Sequencer FSM; handshake flags are registered alongside the state so the
   // ports carry no combinational path from any input.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
         mac_a_q     <= '0;
         mac_b_q     <= '0;
         mac_c_q     <= '0;
         out_data_q  <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  acc_q  <= bias_i;
                  busy_q <= 1'b1;
                  if (len_i != '0) begin
                     rem_q      <= len_i;
                     in_ready_q <= 1'b1;
                     state_q    <= FEED;
                  end else begin
                     // Empty vector: the result is just the bias.
                     out_data_q  <= bias_i;
                     out_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end
               end
            end
            FEED: begin
               if (in_valid_i && in_ready_q) begin
                  mac_a_q    <= in_a_i;
                  mac_b_q    <= in_b_i;
                  mac_c_q    <= acc_q;
                  cnt_q      <= CNT_W'(MAC_LAT);
                  in_ready_q <= 1'b0;
                  state_q    <= WAIT;
               end
            end
            WAIT: begin
               if (cnt_q == '0) begin
                  acc_q <= mac_y_i;
                  rem_q <= rem_d;
                  if (rem_d == '0) begin
                     out_data_q  <= mac_y_i;
                     out_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end else begin
                     in_ready_q <= 1'b1;
                     state_q    <= FEED;
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            DONE: begin
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               in_ready_q  <= 1'b0;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign busy_o      = busy_q;
   assign mac_a_o     = mac_a_q;
   assign mac_b_o     = mac_b_q;
   assign mac_c_o     = mac_c_q;
   assign out_data_o  = out_data_q;

endmodule : tinyml_dot_seq
`default_nettype wire

// File: tb/tb_tinyml_dot_seq.sv
`default_nettype none
// ============================================================================
//  Module    : tb_tinyml_dot_seq
//  Purpose   : Self-checking bench for tinyml_dot_seq driving a behavioural
//              one-stage 8x8+16 MAC. Expected results go into a scoreboard
//              queue; a monitor pops and compares on each output handshake.
//  Revision  : 1.0 - initial release
// ============================================================================
module tb_tinyml_dot_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  len = '0;
   logic [15:0] bias = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_a = '0;
   logic [7:0]  in_b = '0;
   logic [7:0]  mac_a;
   logic [7:0]  mac_b;
   logic [15:0] mac_c;
   logic [15:0] mac_y = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_data;
   logic        busy;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   logic [15:0] sb[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural MAC, latency 1: result stable one edge after operands register.
   always @(posedge clk) mac_y <= ({8'h00, mac_a} * {8'h00, mac_b}) + mac_c;

   tinyml_dot_seq #(.LEN_W(8), .MAC_LAT(1)) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .start_i     (start),
      .len_i       (len),
      .bias_i      (bias),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_a_i      (in_a),
      .in_b_i      (in_b),
      .mac_a_o     (mac_a),
      .mac_b_o     (mac_b),
      .mac_c_o     (mac_c),
      .mac_y_i     (mac_y),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .busy_o      (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: an output handshake happens at the next rising edge.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", {16'h0, out_data}, 32'hFFFF_FFFF);
         end else begin
            chk("sb_out_data", {16'h0, out_data}, {16'h0, sb.pop_front()});
         end
      end
   end

   task automatic start_job(input logic [7:0] l, input logic [15:0] b, input logic [15:0] exp);
      sb.push_back(exp);
      start = 1'b1;
      len   = l;
      bias  = b;
      tick();
      start = 1'b0;
   endtask

   task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
      int n = 0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_out();
      int n = 0;
      while (!out_valid && n < 100) begin
         tick();
         n++;
      end
      if (!out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int t0;
      repeat (2) tick();
      chk("reset_busy", {31'h0, busy}, 32'd0);
      chk("reset_in_ready", {31'h0, in_ready}, 32'd0);
      chk("reset_out_valid", {31'h0, out_valid}, 32'd0);
      chk("reset_mac_c", {16'h0, mac_c}, 32'd0);
      reset = 1'b0;
      tick();

      // Job 1: 5 + 3*4 + 10*10 + 2*5 = 127
      out_ready = 1'b1;
      start_job(8'd3, 16'd5, 16'd127);
      t0 = cyc;
      chk("j1_busy", {31'h0, busy}, 32'd1);
      chk("j1_in_ready", {31'h0, in_ready}, 32'd1);
      in_valid = 1'b1;
      send_pair(8'd3, 8'd4);
      in_valid = 1'b1;
      send_pair(8'd10, 8'd10);
      in_valid = 1'b1;
      send_pair(8'd2, 8'd5);
      wait_out();
      chk("j1_latency", cyc - t0, 32'd9);
      tick();
      chk("j1_busy_after", {31'h0, busy}, 32'd0);

      // Job 2: empty vector, result is bias; MAC registers untouched (2,5,117)
      start_job(8'd0, 16'd42, 16'd42);
      chk("j2_out_valid", {31'h0, out_valid}, 32'd1);
      chk("j2_in_ready", {31'h0, in_ready}, 32'd0);
      chk("j2_mac_a", {24'h0, mac_a}, 32'd2);
      chk("j2_mac_b", {24'h0, mac_b}, 32'd5);
      chk("j2_mac_c", {16'h0, mac_c}, 32'd117);
      tick();
      chk("j2_in_ready_after", {31'h0, in_ready}, 32'd0);

      // Jobs 3/4: wrap and maximum product
      start_job(8'd1, 16'hFFFF, 16'h0000);
      send_pair(8'd1, 8'd1);
      wait_out();
      tick();
      start_job(8'd1, 16'h0000, 16'hFE01);
      send_pair(8'd255, 8'd255);
      wait_out();
      tick();

      // Job 5: input gaps, start while busy, output backpressure: 2*3+4*5 = 26
      out_ready = 1'b0;
      start_job(8'd2, 16'd0, 16'd26);
      send_pair(8'd2, 8'd3);
      for (int i = 0; i < 4; i++) begin
         start = (i == 1);
         len   = 8'd0;
         bias  = 16'd99;
         tick();
      end
      start = 1'b0;
      send_pair(8'd4, 8'd5);
      wait_out();
      for (int i = 0; i < 5; i++) begin
         chk("j5_hold_valid", {31'h0, out_valid}, 32'd1);
         chk("j5_hold_data", {16'h0, out_data}, 32'd26);
         tick();
      end
      out_ready = 1'b1;
      tick();
      chk("j5_busy_after", {31'h0, busy}, 32'd0);

      // Job 6: asynchronous reset while the first element is in WAIT
      sb.push_back(16'd0);
      void'(sb.pop_back());
      start = 1'b1;
      len   = 8'd4;
      bias  = 16'd300;
      tick();
      start = 1'b0;
      send_pair(8'd9, 8'd9);
      #2 reset = 1'b1;
      #1;
      chk("rst_busy", {31'h0, busy}, 32'd0);
      chk("rst_in_ready", {31'h0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
      chk("rst_mac_a", {24'h0, mac_a}, 32'd0);
      chk("rst_mac_c", {16'h0, mac_c}, 32'd0);
      chk("rst_out_data", {16'h0, out_data}, 32'd0);
      #1 reset = 1'b0;
      tick();
      chk("rst_stays_idle", {31'h0, busy}, 32'd0);

      // Job 7: fresh job after abort: 7 + 2*2 = 11
      start_job(8'd1, 16'd7, 16'd11);
      send_pair(8'd2, 8'd2);
      wait_out();
      tick();

      repeat (3) tick();
      chk("sb_empty", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_tinyml_dot_seq
`default_nettype wire

// File: doc/tinyml_dot_seq.md
# tinyml_dot_seq

Dot-product sequencer that drives the team's 8x8+16 multiply-accumulate unit (y = a*b + c) from the controller side. It accepts a vector length and a bias, then streams operand pairs into the MAC, feeding each result back as the next addend. It presents the final 16-bit accumulation on a valid/ready output. It sits between the operand source (SRAM reader or host FIFO) and the MAC datapath.

## Interface
- `LEN_W`, 8: width of the vector-length field; maximum length is 2^LEN_W-1.
- `MAC_LAT`, 1: MAC latency in clock edges, from the edge that registers `mac_a/b/c` to the edge after which `mac_y` is stable.
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  pulse that begins a job; sampled only in IDLE.
- `len`  in  LEN_W  number of operand pairs; latched on `start`.
- `bias`  in  16  initial accumulator value; latched on `start`.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  sequencer can accept a pair.
- `in_a`, `in_b`  in  8 each  unsigned operands.
- `mac_a`, `mac_b`  out  8 each  registered operands to the MAC.
- `mac_c`  out  16  registered addend to the MAC; equals the current accumulator.
- `mac_y`  in  16  MAC result.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  16  final accumulation.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, FEED, WAIT, DONE.
- IDLE:
  - On `start` with `len`≠0: `acc`←`bias`, `rem`←`len`, go to FEED.
  - On `start` with `len`=0: `acc`←`bias`, go to DONE.
  - `start` in any other state is ignored.
- FEED: `in_ready`=1. On `in_valid`&&`in_ready`:
  - `mac_a`←`in_a`, `mac_b`←`in_b`, `mac_c`←`acc`.
  - Load the wait counter with `MAC_LAT`; go to WAIT.
- WAIT: `in_ready`=0. The counter decrements each cycle. When it reaches 0:
  - `acc`←`mac_y`, `rem`←`rem`-1.
  - If the new `rem`=0, go to DONE; otherwise go to FEED.
- DONE: `out_valid`=1, `out_data`=`acc`. On `out_ready`, go to IDLE. `out_data` holds stable while `out_valid` is high and `out_ready` is low.
- Arithmetic: unsigned, modulo 2^16. The sequencer never widens and never saturates; overflow wraps inside the MAC.
- In FEED, `in_valid` gaps of any length stall without side effects.
- Reset, asynchronous and at any point including mid-job: state→IDLE; `acc`, `rem`, counter, `mac_a`, `mac_b`, `mac_c`, `out_data`→0; `in_ready`, `out_valid`, `busy`→0. The job is aborted and not resumed.

## Timing
- `start` sampled at edge E: `busy`=1 after E. `in_ready`=1 after E (len≠0); `out_valid`=1 after E (len=0).
- Handshake at edge L: `mac_a/b/c` valid after L. `acc` captures `mac_y` at edge L+MAC_LAT+1. FEED or DONE is entered at that same edge.
- Per-element period: MAC_LAT+2 cycles with `in_valid` held high. That is 3 cycles at the default.
- Job latency: len×(MAC_LAT+2) cycles from the `start` edge to `out_valid` high, plus any input stalls.
- `out_valid`&&`out_ready` at edge D: IDLE after D. `start` is accepted at D+1 at the earliest.
- `in_ready` and `out_valid` are decoded from registered state, with no combinational path from inputs. `mac_*` and `out_data` are registers.

## Structure
- Shared package `tinyml_pkg`:
  - `DATA_W`=8 and `ACC_W`=16.
  - State enum `dot_state_t` {IDLE, FEED, WAIT, DONE}.
  - The same widths are shared by the MAC.
- No sub-module. The MAC stays external, so the sequencer can be reused with pipelined MAC variants by changing `MAC_LAT`.
- The bench instantiates the sequencer and the existing MAC together.

## Test plan
- len=3, bias=5, pairs (3,4),(10,10),(2,5), `out_ready`=1 → `out_data`=127 (0x007F). `out_valid` rises 9 cycles after `start`; `busy` falls after acceptance.
- len=0, bias=42 → `out_valid` the cycle after `start`, `out_data`=42, no `in_ready` pulse and no `mac_*` change.
- len=1, bias=0xFFFF, pair (1,1) → `out_data`=0x0000 (wrap). Then len=1, bias=0, pair (255,255) → 0xFE01.
- len=2, bias=0, pairs (2,3),(4,5), `in_valid` low 4 cycles between the pairs and `out_ready` low 5 cycles → `out_data`=26 held stable throughout backpressure, and `start` asserted while busy is ignored.
- reset asserted mid-WAIT of a len=4 job → all outputs 0 immediately (async). A new job (len=1, bias=7, pair (2,2)) then yields 11.
